// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the serial pattern detector/counter.
package seq_pattern_pkg;

   // Widest supported pattern; config storage is sized for it so the
   // struct is independent of any one instance's MAX_LEN.
   localparam int CFG_PAT_W = 32;

   // Width needed to hold a length value in the range 0..max_len.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   localparam int CFG_LEN_W = len_w(CFG_PAT_W);

   localparam logic [CFG_PAT_W-1:0] DEFAULT_PAT_VAL = 32'b0101;
   localparam int                   DEFAULT_LEN_VAL = 4;

   // Runtime configuration; pattern bits above the active length are zero.
   typedef struct packed {
      logic [CFG_PAT_W-1:0] pat;
      logic [CFG_LEN_W-1:0] len;
      logic                 overlap;
      logic                 wrap;
   } cfg_t;

endpackage

// File: rtl/seq_pattern_counter_event_counter.sv
// Occurrence counter with wrap/saturate selection and sticky overflow.
module event_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             wrap,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             of
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             of_q, of_d;

   // Next count: clear wins, otherwise increment with wrap or saturation at max.
   always_comb begin
      cnt_d = cnt_q;
      of_d  = of_q;
      if (clr) begin
         cnt_d = '0;
         of_d  = 1'b0;
      end else if (inc) begin
         if (cnt_q == '1) begin
            of_d  = 1'b1;
            cnt_d = wrap ? '0 : cnt_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Count and overflow registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         of_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         of_q  <= of_d;
      end
   end

   assign cnt = cnt_q;
   assign of  = of_q;

endmodule

// File: rtl/seq_pattern_counter.sv
// Programmable serial pattern detector feeding an occurrence counter.
module seq_pattern_counter
   import seq_pattern_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(DEFAULT_PAT_VAL),
   parameter int                 DEFAULT_LEN = DEFAULT_LEN_VAL
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        bit_valid,
   input  logic                        bit_i,
   input  logic                        clr,
   input  logic                        cfg_we,
   input  logic [MAX_LEN-1:0]          cfg_pat,
   input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
   input  logic                        cfg_overlap,
   input  logic                        cfg_wrap,
   output logic                        match_o,
   output logic [CNT_W-1:0]            cnt,
   output logic                        of,
   output logic                        cfg_err
);

   localparam int   LEN_W   = len_w(MAX_LEN);
   localparam cfg_t CFG_RST = '{pat:     CFG_PAT_W'(DEFAULT_PAT),
                                len:     CFG_LEN_W'(DEFAULT_LEN),
                                overlap: 1'b1,
                                wrap:    1'b0};

   cfg_t                 cfg_q, cfg_d;
   logic [MAX_LEN-1:0]   hist_q, hist_d;
   logic [LEN_W-1:0]     fill_q, fill_d;
   logic                 match_q, match_d;
   logic                 err_q, err_d;

   logic [MAX_LEN-1:0]   nh;
   logic [CFG_PAT_W-1:0] mask;
   logic [CFG_LEN_W-1:0] fill_next;
   logic                 cfg_ok;
   logic                 hit;
   logic                 inc;

   // The oldest history bit is shifted out before it can ever be compared.
   logic unused_hist_msb;
   assign unused_hist_msb = hist_q[MAX_LEN-1];

   // Match evaluation on the history as it would look after shifting in bit_i.
   always_comb begin
      nh = {hist_q[MAX_LEN-2:0], bit_i};
      mask = '0;
      for (int unsigned i = 0; i < CFG_PAT_W; i++) begin
         mask[i] = (i < 32'(cfg_q.len));
      end
      fill_next = CFG_LEN_W'(fill_q) + CFG_LEN_W'(1);
      hit = (fill_next >= cfg_q.len) &&
            (((CFG_PAT_W'(nh) ^ cfg_q.pat) & mask) == '0);
      cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   end

   // Next state: clr > cfg_we > bit_valid; a bit arriving with clr/cfg_we is dropped.
   always_comb begin
      cfg_d   = cfg_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      err_d   = 1'b0;
      inc     = 1'b0;
      if (clr) begin
         hist_d = '0;
         fill_d = '0;
      end else if (cfg_we) begin
         if (cfg_ok) begin
            cfg_d  = '{pat:     CFG_PAT_W'(cfg_pat),
                       len:     CFG_LEN_W'(cfg_len),
                       overlap: cfg_overlap,
                       wrap:    cfg_wrap};
            hist_d = '0;
            fill_d = '0;
         end else begin
            err_d = 1'b1;
         end
      end else if (bit_valid) begin
         hist_d = nh;
         fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
         if (hit) begin
            match_d = 1'b1;
            inc     = 1'b1;
            if (!cfg_q.overlap) begin
               fill_d = '0;
            end
         end
      end
   end

   // Config, history and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q   <= CFG_RST;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cfg_q   <= cfg_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         err_q   <= err_d;
      end
   end

   event_counter #(.CNT_W(CNT_W)) u_event_counter (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc),
      .wrap (cfg_q.wrap),
      .clr  (clr),
      .cnt  (cnt),
      .of   (of)
   );

   assign match_o = match_q;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Directed bench for seq_pattern_counter with a per-cycle scoreboard.
module tb_seq_pattern_counter;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 4;
   localparam int LEN_W   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, bit_valid, bit_i, clr, cfg_we, cfg_overlap, cfg_wrap;
   logic [MAX_LEN-1:0] cfg_pat;
   logic [LEN_W-1:0]   cfg_len;
   logic               match_o, of, cfg_err;
   logic [CNT_W-1:0]   cnt;

   seq_pattern_counter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bit_valid   (bit_valid),
      .bit_i       (bit_i),
      .clr         (clr),
      .cfg_we      (cfg_we),
      .cfg_pat     (cfg_pat),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_wrap    (cfg_wrap),
      .match_o     (match_o),
      .cnt         (cnt),
      .of          (of),
      .cfg_err     (cfg_err)
   );

   typedef struct {
      logic             m;
      logic [CNT_W-1:0] c;
      logic             o;
      logic             e;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model: bits received since the last history clear, oldest first.
   bit         m_bits[$];
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ov, m_wr, m_of;
   int         m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic b, input logic c,
                        input logic w, input logic [7:0] p, input logic [3:0] l,
                        input logic ov, input logic wr, input string tag);
      exp_t e;
      bit   h;
      int   n;
      @(negedge clk);
      rst = r; bit_valid = v; bit_i = b; clr = c; cfg_we = w;
      cfg_pat = p; cfg_len = l; cfg_overlap = ov; cfg_wrap = wr;
      e.m = 1'b0; e.e = 1'b0;
      if (r) begin
         m_cnt = 0; m_of = 0; m_bits.delete();
         m_pat = 8'b0101; m_len = 4; m_ov = 1; m_wr = 0;
      end else if (c) begin
         m_cnt = 0; m_of = 0; m_bits.delete();
      end else if (w) begin
         if (l >= 1 && l <= MAX_LEN) begin
            m_pat = p; m_len = int'(l); m_ov = ov; m_wr = wr; m_bits.delete();
         end else begin
            e.e = 1'b1;
         end
      end else if (v) begin
         m_bits.push_back(b);
         if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
         n = m_bits.size();
         h = (n >= m_len);
         for (int k = 0; k < m_len && h; k++)
            if (m_bits[n-1-k] != m_pat[k]) h = 0;
         if (h) begin
            e.m = 1'b1;
            if (m_cnt == 15) begin
               m_of = 1;
               if (m_wr) m_cnt = 0;
            end else begin
               m_cnt++;
            end
            if (!m_ov) m_bits.delete();
         end
      end
      e.c = CNT_W'(m_cnt);
      e.o = m_of;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".match"}, 32'(match_o), 32'(e.m));
      chk({tag, ".cnt"},   32'(cnt),     32'(e.c));
      chk({tag, ".of"},    32'(of),      32'(e.o));
      chk({tag, ".err"},   32'(cfg_err), 32'(e.e));
   endtask

   task automatic do_reset(input string tag);
      drive(1, 1, 1, 0, 0, 8'h0, 4'h0, 0, 0, tag);
   endtask

   task automatic do_clr(input string tag);
      drive(0, 0, 0, 1, 0, 8'h0, 4'h0, 0, 0, tag);
   endtask

   task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                      input logic ov, input logic wr, input string tag);
      drive(0, 0, 0, 0, 1, p, l, ov, wr, tag);
   endtask

   // Sends s[n-1] first; gap idle cycles follow every bit.
   task automatic send(input logic [31:0] s, input int n, input int gap, input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         drive(0, 1, s[i], 0, 0, 8'h0, 4'h0, 0, 0, tag);
         repeat (gap) drive(0, 0, 0, 0, 0, 8'h0, 4'h0, 0, 0, {tag, ".idle"});
      end
   endtask

   initial begin
      rst = 1'b1; bit_valid = 0; bit_i = 0; clr = 0; cfg_we = 0;
      cfg_pat = '0; cfg_len = '0; cfg_overlap = 0; cfg_wrap = 0;

      do_reset("rst");
      chk("rst.cnt", 32'(cnt), 0);
      chk("rst.of", 32'(of), 0);

      send(32'b010101, 6, 0, "ovl");
      chk("ovl.cnt", 32'(cnt), 2);
      chk("ovl.of", 32'(of), 0);

      do_clr("c1");
      cfg(8'b0101, 4, 0, 0, "nov.cfg");
      send(32'b010101, 6, 0, "nov6");
      chk("nov6.cnt", 32'(cnt), 1);
      do_clr("c2");
      send(32'b01010101, 8, 0, "nov8");
      chk("nov8.cnt", 32'(cnt), 2);
      do_clr("c3");
      send(32'b010101, 6, 2, "novgap");
      chk("novgap.cnt", 32'(cnt), 1);
      do_clr("c4");
      cfg(8'b0101, 4, 1, 0, "ovgap.cfg");
      send(32'b010101, 6, 3, "ovgap");
      chk("ovgap.cnt", 32'(cnt), 2);

      do_clr("c5");
      cfg(8'b110, 3, 1, 0, "p110.cfg");
      send(32'b11011011, 8, 0, "p110");
      chk("p110.cnt", 32'(cnt), 2);
      cfg(8'b1, 1, 1, 0, "p1.cfg");
      chk("p1.cfgkeep", 32'(cnt), 2);
      send(32'b101, 3, 0, "p1");
      chk("p1.cnt", 32'(cnt), 4);

      do_clr("c6");
      send(32'hFFFF, 16, 0, "sat");
      chk("sat.cnt", 32'(cnt), 15);
      chk("sat.of", 32'(of), 1);
      send(32'b1, 1, 0, "sat17");
      chk("sat17.match", 32'(match_o), 1);
      chk("sat17.cnt", 32'(cnt), 15);
      do_clr("c7");
      chk("c7.of", 32'(of), 0);
      cfg(8'b1, 1, 1, 1, "wrap.cfg");
      send(32'hFFFF, 16, 0, "wrap");
      chk("wrap.cnt", 32'(cnt), 0);
      chk("wrap.of", 32'(of), 1);

      do_reset("r2");
      cfg(8'hAA, 0, 0, 1, "bad0");
      chk("bad0.err", 32'(cfg_err), 1);
      cfg(8'hAA, 9, 0, 1, "bad9");
      chk("bad9.err", 32'(cfg_err), 1);
      send(32'b0101, 4, 0, "dflt");
      chk("dflt.cnt", 32'(cnt), 1);

      do_reset("r3");
      send(32'b010, 3, 0, "pc");
      do_clr("pc.clr");
      send(32'b1, 1, 0, "pc.1");
      chk("pc.match", 32'(match_o), 0);
      chk("pc.cnt", 32'(cnt), 0);
      send(32'b010, 3, 0, "pr");
      do_reset("pr.rst");
      send(32'b1, 1, 0, "pr.1");
      chk("pr.match", 32'(match_o), 0);
      send(32'b010, 3, 0, "cb");
      drive(0, 1, 1, 1, 0, 8'h0, 4'h0, 0, 0, "cb.clrbit");
      send(32'b1, 1, 0, "cb.1");
      chk("cb.match", 32'(match_o), 0);
      send(32'b010, 3, 0, "wb");
      drive(0, 1, 1, 0, 1, 8'b0101, 4, 1, 0, "wb.cfgbit");
      send(32'b1, 1, 0, "wb.1");
      chk("wb.match", 32'(match_o), 0);
      send(32'b0101, 4, 0, "wb.full");
      chk("wb.cnt", 32'(cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
